frog_key_cmd: RTL and testbench

- Upstream stage of frogger_game. Converts the raw 16-bit USB keycode word from the NIOS keycode PIO into discrete, frame-paced frog move commands.
- Handles press edge detection and auto-repeat while a key is held.
- Queues commands in a small FIFO drained by the game through a valid/ready handshake.
- Emits a one-cycle pause-toggle pulse for the space bar.

---
 rtl/frog_key_cmd_pkg.sv | 66 ++++++
 rtl/frog_cmd_fifo.sv | 63 ++++++
 rtl/frog_key_cmd.sv | 142 ++++++++++++++
 tb/tb_frog_key_cmd.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/frog_key_cmd_pkg.sv
// Shared types, keycodes and key-decode helpers for the frog key command path.
// Build option: define FROG_KEY_ARROW_EN to also decode the arrow keys as moves.
package frogger_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } move_dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  localparam logic [7:0] KEY_W      = 8'h1A;
  localparam logic [7:0] KEY_A      = 8'h04;
  localparam logic [7:0] KEY_S      = 8'h16;
  localparam logic [7:0] KEY_D      = 8'h07;
  localparam logic [7:0] KEY_SPACE  = 8'h2C;
  localparam logic [7:0] KEY_UP_ARR = 8'h52;
  localparam logic [7:0] KEY_DN_ARR = 8'h51;
  localparam logic [7:0] KEY_LT_ARR = 8'h50;
  localparam logic [7:0] KEY_RT_ARR = 8'h4F;

  typedef struct packed {
    logic      hit;
    move_dir_t dir;
  } key_dec_t;

  // Map one HID usage byte to a direction; hit is low for non-direction keys.
  function automatic key_dec_t decode_byte(input logic [7:0] code);
    key_dec_t d;
    d.hit = 1'b1;
    d.dir = UP;
    case (code)
      KEY_W: d.dir = UP;
      KEY_S: d.dir = DOWN;
      KEY_A: d.dir = LEFT;
      KEY_D: d.dir = RIGHT;
`ifdef FROG_KEY_ARROW_EN
      KEY_UP_ARR: d.dir = UP;
      KEY_DN_ARR: d.dir = DOWN;
      KEY_LT_ARR: d.dir = LEFT;
      KEY_RT_ARR: d.dir = RIGHT;
`endif
      default: begin
        d.hit = 1'b0;
        d.dir = UP;
      end
    endcase
    return d;
  endfunction

  // The first held key wins; the second is only consulted when the first is not a move.
  function automatic key_dec_t decode_key(input logic [15:0] kc);
    key_dec_t lo;
    key_dec_t hi;
    lo = decode_byte(kc[7:0]);
    hi = decode_byte(kc[15:8]);
    return lo.hit ? lo : hi;
  endfunction

endpackage

// File: rtl/frog_cmd_fifo.sv
// Small command queue with valid/ready drain; full-with-pop still accepts a push.
module frog_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             valid_r;
  logic             pop_s;
  logic             do_push_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Handshake and occupancy next-state.
  always_comb begin
    pop_s       = valid_r & pop_ready;
    full        = (count_r == FULL_CNT);
    do_push_s   = push & (~full | pop_s);
    count_nxt_s = count_r;
    case ({do_push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
      2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers (wrap naturally at the power-of-two depth) and registered valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != '0);
    end
  end

  assign valid = valid_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/frog_key_cmd.sv
// Converts the held-keycode word into frame-paced frog move commands with
// auto-repeat, a pause-toggle pulse for space, and a queued valid/ready output.
// Build option: FROG_KEY_ARROW_EN adds arrow-key decoding (see frogger_pkg).
module frog_key_cmd
  import frogger_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  output logic        move_valid,
  output logic [1:0]  move_dir,
  input  logic        move_ready,
  output logic        pause_toggle,
  output logic        overflow
);

  localparam int MAX_RPT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_RPT) + 1;
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic          sync1_r, sync2_r, prev_r, tick_r;
  logic [1:0]    settle_r;
  key_state_t    state_r;
  logic [CW-1:0] cnt_r;
  move_dir_t     latched_r;
  logic          space_prev_r, pause_r, overflow_r;
  key_dec_t      dec_s;
  logic          space_s, push_s, pop_s, full_s;

  // Synchronise frame_clk and form the registered tick; the settle count blocks a
  // level that was already high across reset from looking like a fresh edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      prev_r   <= 1'b0;
      tick_r   <= 1'b0;
      settle_r <= 2'd0;
    end else begin
      sync1_r <= frame_clk;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (settle_r != 2'd3) settle_r <= settle_r + 2'd1;
      tick_r  <= sync2_r & ~prev_r & (settle_r == 2'd3);
    end
  end

  // Decode the keycode word and decide whether this tick pushes a command.
  always_comb begin
    dec_s   = decode_key(keycode);
    space_s = (keycode[7:0] == KEY_SPACE) | (keycode[15:8] == KEY_SPACE);
    pop_s   = move_valid & move_ready;
    push_s  = 1'b0;
    if (tick_r && dec_s.hit) begin
      case (state_r)
        IDLE:    push_s = 1'b1;
        DELAY:   push_s = (dec_s.dir != latched_r) || (cnt_r == DELAY_LAST);
        REPEAT:  push_s = (dec_s.dir != latched_r) || (cnt_r == PERIOD_LAST);
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Repeat FSM: advances only on ticks, restarting the delay on a new direction.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      latched_r <= UP;
    end else if (tick_r) begin
      case (state_r)
        IDLE: begin
          if (dec_s.hit) begin
            latched_r <= dec_s.dir;
            cnt_r     <= '0;
            state_r   <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!dec_s.hit) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else if (dec_s.dir != latched_r) begin
            latched_r <= dec_s.dir;
            cnt_r     <= '0;
            state_r   <= DELAY;
          end else if ((state_r == DELAY) && (cnt_r == DELAY_LAST)) begin
            cnt_r   <= '0;
            state_r <= REPEAT;
          end else if ((state_r == REPEAT) && (cnt_r == PERIOD_LAST)) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Space press edge to a one-cycle pause pulse, and sticky overflow on a dropped push.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      space_prev_r <= 1'b0;
      pause_r      <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      pause_r <= tick_r & space_s & ~space_prev_r;
      if (tick_r) space_prev_r <= space_s;
      if (push_s && full_s && !pop_s) overflow_r <= 1'b1;
    end
  end

  frog_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push_s),
    .push_data (dec_s.dir),
    .pop_ready (move_ready),
    .valid     (move_valid),
    .head      (move_dir),
    .full      (full_s)
  );

  assign pause_toggle = pause_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_frog_key_cmd.sv
// Directed bench for frog_key_cmd with hand-computed expectations.
module tb_frog_key_cmd;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [15:0] keycode;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;
  logic        pause_toggle;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_no = 0;
  int acc_n = 0;
  int pause_n = 0;
  logic [1:0] acc_dir [256];
  int         acc_frm [256];
  int         pause_frm [16];
  int base, base_f, pbase;

  frog_key_cmd dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .move_valid   (move_valid),
    .move_dir     (move_dir),
    .move_ready   (move_ready),
    .pause_toggle (pause_toggle),
    .overflow     (overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Record every accepted command and every pause pulse with its frame number.
  always @(posedge Clk) begin
    if (!Reset) begin
      if (move_valid && move_ready) begin
        acc_dir[acc_n[7:0]] <= move_dir;
        acc_frm[acc_n[7:0]] <= frame_no;
        acc_n <= acc_n + 1;
      end
      if (pause_toggle) begin
        pause_frm[pause_n[3:0]] <= frame_no;
        pause_n <= pause_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame: frame_clk high 4 cycles then low 4 cycles, rising just after a Clk edge.
  task automatic frame();
    frame_no++;
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_valid", move_valid, 0);
    chk("rst_pause", pause_toggle, 0);
    chk("rst_ovf", overflow, 0);
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  logic [15:0] codes [5];

  initial begin
    codes = '{16'h001A, 16'h0016, 16'h0004, 16'h0007, 16'h001A};
    Reset = 1'b1; frame_clk = 1'b0; keycode = 16'h0000; move_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("init_valid", move_valid, 0);
    chk("init_dir", move_dir, 0);
    chk("init_pause", pause_toggle, 0);
    chk("init_ovf", overflow, 0);
    @(negedge Clk); Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    // Single press: valid appears 4 cycles after the frame_clk rise.
    base = acc_n;
    keycode = 16'h001A;
    frame_no++;
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 chk("t1_valid_c3", move_valid, 0);
    @(posedge Clk);
    #1 chk("t1_valid_c4", move_valid, 1);
    chk("t1_dir_c4", move_dir, 0);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1 keycode = 16'h0000;
    frame();
    chk("t1_count", acc_n - base, 1);
    chk("t1_dir", acc_dir[base], 0);

    // Auto-repeat: RIGHT held 30 frames pushes on frames 1, 16, 22, 28.
    base = acc_n; base_f = frame_no;
    keycode = 16'h0007;
    repeat (30) frame();
    keycode = 16'h0000;
    frame();
    chk("t2_count", acc_n - base, 4);
    chk("t2_f0", acc_frm[base] - base_f, 1);
    chk("t2_f1", acc_frm[base+1] - base_f, 16);
    chk("t2_f2", acc_frm[base+2] - base_f, 22);
    chk("t2_f3", acc_frm[base+3] - base_f, 28);
    chk("t2_dir", acc_dir[base+3], 3);

    // Byte priority then direction change restarts the repeat delay.
    base = acc_n;
    keycode = 16'h1604; frame();
    keycode = 16'h0016; frame();
    chk("t3_count2", acc_n - base, 2);
    chk("t3_left", acc_dir[base], 2);
    chk("t3_down", acc_dir[base+1], 1);
    repeat (14) frame();
    chk("t3_no_early_rpt", acc_n - base, 2);
    frame();
    chk("t3_rpt", acc_n - base, 3);
    chk("t3_rpt_dir", acc_dir[base+2], 1);
    keycode = 16'h0000; frame();

    // Overflow: five presses with the consumer stalled; the fifth is dropped.
    move_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      keycode = codes[i]; frame();
      keycode = 16'h0000; frame();
      if (i == 3) chk("t4_ovf_at_full", overflow, 0);
    end
    chk("t4_ovf", overflow, 1);
    chk("t4_valid", move_valid, 1);
    chk("t4_head", move_dir, 0);
    base = acc_n;
    move_ready = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    chk("t4_drained", acc_n - base, 4);
    for (int i = 0; i < 4; i++) chk("t4_order", acc_dir[base+i], i);
    chk("t4_ovf_sticky", overflow, 1);
    chk("t4_empty", move_valid, 0);

    do_reset();

    // Pause: space held 10 frames gives one pulse on the first tick, no moves.
    base = acc_n; base_f = frame_no; pbase = pause_n;
    keycode = 16'h2C00;
    repeat (10) frame();
    keycode = 16'h0000; frame();
    chk("t5_pulses", pause_n - pbase, 1);
    chk("t5_pulse_frame", pause_frm[pbase] - base_f, 1);
    chk("t5_no_moves", acc_n - base, 0);

    // Reset mid-hold with 3 queued; a frame_clk edge during reset is ignored.
    move_ready = 1'b0;
    keycode = 16'h001A;
    repeat (22) frame();
    chk("t6_queued", move_valid, 1);
    @(negedge Clk); Reset = 1'b1; frame_clk = 1'b1;
    #1 chk("t6_valid_in_rst", move_valid, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (6) @(posedge Clk);
    #1 chk("t6_no_stale_tick", move_valid, 0);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    frame();
    chk("t6_press_valid", move_valid, 1);
    chk("t6_press_dir", move_dir, 0);
    base = acc_n;
    move_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1 chk("t6_one_cmd", acc_n - base, 1);
    keycode = 16'h0000; frame();

    // Arrow key: decoded only when the arrow option is built in.
    base = acc_n;
    keycode = 16'h0052; frame();
    keycode = 16'h0000; frame();
`ifdef FROG_KEY_ARROW_EN
    chk("t7_arrow", acc_n - base, 1);
    chk("t7_arrow_dir", acc_dir[base], 0);
`else
    chk("t7_arrow", acc_n - base, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
